// File: rtl/mem_bridge.sv
`default_nettype none
//============================================================================
// Module   : mem_bridge
// Brief    : M-stage load/store bridge to data memory and MMIO timers/IG.
// Revision : 1.0 - initial release
//============================================================================
module mem_bridge (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_byteen,
  input  logic        req_kill,
  output logic        stall,
  output logic [31:0] M_readData,
  output logic        exc_adr,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_byteen,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ready,
  output logic [31:0] dev_addr,
  output logic [31:0] dev_wdata,
  output logic        tc0_we,
  output logic        tc1_we,
  output logic        ig_we,
  input  logic [31:0] tc0_rdata,
  input  logic [31:0] tc1_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DM_WAIT = 2'd1,
    RESP    = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_readData;
  logic [31:0] r_dmAddr;
  logic [31:0] r_dmWdata;
  logic [3:0]  r_dmByteen;
  logic        r_dmWe;

  logic        w_inDm;
  logic        w_inTc0;
  logic        w_inTc1;
  logic        w_inIg;
  logic        w_inDev;
  logic        w_illegal;
  logic        w_idleReq;
  logic        w_go;
  logic        w_issueDm;
  logic        w_issueDev;
  logic        w_dmBusy;
  logic [3:0]  w_reqByteen;

  // Address decode; timers expose three words, the fourth slot is unmapped.
  assign w_inDm  = (req_addr < 32'h0000_3000);
  assign w_inTc0 = (req_addr[31:4] == 28'h00007F0) && (req_addr[3:2] != 2'b11);
  assign w_inTc1 = (req_addr[31:4] == 28'h00007F1) && (req_addr[3:2] != 2'b11);
  assign w_inIg  = (req_addr[31:2] == 30'h00001FC8);
  assign w_inDev = w_inTc0 | w_inTc1 | w_inIg;

  assign w_illegal = ~(w_inDm | w_inDev)
                   | (w_inDev & req_we & (req_byteen != 4'b1111))
                   | ((w_inTc0 | w_inTc1) & req_we & (req_addr[3:2] == 2'b10))
                   | (w_inDev & ~req_we & (req_addr[1:0] != 2'b00));

  assign w_idleReq  = (r_state == IDLE) & req_valid & ~reset;
  assign w_go       = w_idleReq & ~w_illegal & ~req_kill;
  assign w_issueDm  = w_go & w_inDm;
  assign w_issueDev = w_go & w_inDev;
  assign w_dmBusy   = (r_state == DM_WAIT) | (r_state == DRAIN);

  // Loads always fetch the full word; the extension stage picks the lanes.
  assign w_reqByteen = req_we ? req_byteen : 4'b1111;

  assign exc_adr    = w_idleReq & w_illegal;
  assign stall      = w_go | w_dmBusy;
  assign M_readData = exc_adr ? 32'h0 : r_readData;

  always_comb begin
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = 32'h0;
    dm_wdata  = 32'h0;
    dm_byteen = 4'h0;
    dev_addr  = 32'h0;
    dev_wdata = 32'h0;
    tc0_we    = 1'b0;
    tc1_we    = 1'b0;
    ig_we     = 1'b0;
    if (w_issueDm) begin
      dm_req    = 1'b1;
      dm_we     = req_we;
      dm_addr   = req_addr;
      dm_wdata  = req_wdata;
      dm_byteen = w_reqByteen;
    end else if (w_dmBusy) begin
      dm_req    = 1'b1;
      dm_we     = r_dmWe;
      dm_addr   = r_dmAddr;
      dm_wdata  = r_dmWdata;
      dm_byteen = r_dmByteen;
    end
    if (w_issueDev) begin
      dev_addr  = req_addr;
      dev_wdata = req_wdata;
      tc0_we    = req_we & w_inTc0;
      tc1_we    = req_we & w_inTc1;
      ig_we     = req_we & w_inIg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_readData <= 32'h0;
      r_dmAddr   <= 32'h0;
      r_dmWdata  <= 32'h0;
      r_dmByteen <= 4'h0;
      r_dmWe     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issueDm) begin
            r_dmWe     <= req_we;
            r_dmAddr   <= req_addr;
            r_dmWdata  <= req_wdata;
            r_dmByteen <= w_reqByteen;
            if (dm_ready) begin
              r_readData <= dm_rdata;
              r_state    <= RESP;
            end else begin
              r_state <= DM_WAIT;
            end
          end else if (w_issueDev) begin
            if (!req_we) begin
              r_readData <= w_inTc0 ? tc0_rdata :
                            w_inTc1 ? tc1_rdata : 32'h0;
            end
            r_state <= RESP;
          end
        end
        DM_WAIT: begin
          // A kill coinciding with the handshake finishes it and drops the data.
          if (dm_ready) begin
            if (req_kill) begin
              r_state <= IDLE;
            end else begin
              r_readData <= dm_rdata;
              r_state    <= RESP;
            end
          end else if (req_kill) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (dm_ready) begin
            r_state <= IDLE;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_bridge.md
# mem_bridge

Memory-stage bus bridge sitting directly upstream of the load-extension stage. It takes one load/store request per M-stage instruction, decodes the address into data memory or a memory-mapped device (Timer0, Timer1, interrupt generator), and runs the access handshake. It stalls the pipeline until the access completes, then presents the raw 32-bit word on `M_readData` for sign/zero extension downstream. It also flags out-of-range or illegal device accesses as address exceptions.

## Interface
- No parameters; address map fixed below.
- `clk` in 1 — single clock, rising edge.
- `reset` in 1 — asynchronous, active-high.
- `req_valid` in 1 — M stage holds a load or store (held stable while `stall`=1).
- `req_we` in 1 — 1 store, 0 load.
- `req_addr` in 32 — byte address.
- `req_wdata` in 32 — store data, already lane-shifted.
- `req_byteen` in 4 — store byte enables (ignored for loads).
- `req_kill` in 1 — exception/eret flush of the current M instruction.
- `stall` out 1 — freeze F/D/E/M.
- `M_readData` out 32 — raw load word to the extension stage.
- `exc_adr` out 1 — address exception (AdEL if load, AdES if store), combinational.
- `dm_req`, `dm_we` out 1; `dm_addr` out 32; `dm_wdata` out 32; `dm_byteen` out 4; `dm_rdata` in 32; `dm_ready` in 1.
- `dev_addr` out 32; `dev_wdata` out 32; `tc0_we`, `tc1_we`, `ig_we` out 1; `tc0_rdata`, `tc1_rdata` in 32 (combinational device reads).

## Operation
- Decode on `req_addr`: DM 0x0000_0000–0x0000_2FFF; TC0 0x7F00–0x7F0B; TC1 0x7F10–0x7F1B; IG 0x7F20–0x7F23; anything else is illegal.
- Illegal: address outside the map; device store with `req_byteen`≠4'b1111; store to a timer count register (offset 8); any load from a device that is not word-sized (`req_addr[1:0]`≠0). Illegal means `exc_adr`=1 while `req_valid`=1 in IDLE. No access is issued, `stall` stays 0, and `M_readData`=0.
- States: IDLE, DM_WAIT, RESP, DRAIN.
- IDLE, legal DM access: drive `dm_*` from the request and set `stall`=1. If `dm_ready`=1 in the same cycle, capture `dm_rdata` and go to RESP. Otherwise go to DM_WAIT.
- DM_WAIT: hold `dm_req`=1 and all `dm_*` outputs stable, and keep `stall`=1. On `dm_ready`, capture `dm_rdata` and go to RESP.
- IDLE, legal device access: assert the matching `*_we` for this cycle only (stores). For loads, capture the selected `tcX_rdata` (IG reads as 0). Set `stall`=1 and go to RESP.
- RESP: `stall`=0, `M_readData`=captured word. The pipeline advances at this edge. Return to IDLE.
- `req_kill` in IDLE: no access is issued. In RESP: return to IDLE normally. In DM_WAIT: go to DRAIN.
- DRAIN: continue the DM handshake (`dm_req` held), keep `stall`=1, discard data on `dm_ready`, then return to IDLE.
- A killed DM store that was already issued completes. The flush logic upstream must not issue a kill once a store is in flight; the bridge does not roll back.
- `M_readData` holds the last captured word outside RESP.

## Timing
- Reset values: state IDLE. `stall`, `exc_adr`, `dm_req`, `dm_we`, and all `*_we` are 0. `dm_*`/`dev_*` address/data/byteen are 0. `M_readData`=0.
- Reset mid-access abandons the handshake immediately. The DM model must tolerate `dm_req` dropping.
- Device access latency: 1 stall cycle (IDLE), then RESP.
- DM access latency: N+1 stall cycles, where N is the number of cycles after issue until `dm_ready` (N=0 allowed), then RESP.
- Exactly one RESP cycle per completed, non-killed request.
- Back-to-back requests: the next request is seen in IDLE the cycle after RESP. There is no bubble beyond RESP.
- `dm_ready` outside DM_WAIT/DRAIN/IDLE-issue is ignored.

## Test plan
- Load 0x0000_1004 with DM `dm_ready` 2 cycles after issue returning 0xDEADBEEF -> `stall`=1 for 3 cycles, then 1 RESP cycle with `M_readData`=0xDEADBEEF, `dm_req` dropping in RESP.
- Store byte to 0x0000_0003 with `req_byteen`=4'b1000 and `dm_ready` in the issue cycle -> `dm_we`=1, `dm_byteen`=4'b1000, 1 stall cycle, then RESP.
- Load 0x7F14 with `tc1_rdata`=0x0000_0055 -> `tc1_we`=0, 1 stall cycle, `M_readData`=0x55. Store 0x7F08 -> `exc_adr`=1, `tc0_we`=0, `stall`=0.
- Load 0x0000_3000 and store 0x7F04 with `req_byteen`=4'b0011 -> `exc_adr`=1 in both cases, with no `dm_req` and no `*_we`.
- `req_kill` during DM_WAIT with `dm_ready` 3 cycles later -> `stall` held until the drain completes, no RESP, `M_readData` unchanged.
- `reset` asserted in DM_WAIT -> all outputs 0 asynchronously. After release, a new TC0 load completes normally.
